// File: rtl/hd_trace_sampler.sv
// hd_trace_sampler
//   Hamming-distance power-proxy sampler. Counts bit toggles on a bus of
//   monitored nets between consecutive rising edges, sums them over a window
//   of WIN cycles and queues each window sum in an output FIFO.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   nets       monitored net values (WIDTH bits)
//   start      pulse: begin a trace (accepted only in IDLE with nsamp != 0)
//   nsamp      samples per trace, latched on an accepted start
//   out_valid  FIFO head valid
//   out_ready  consumer accepts the head
//   out_data   head sample (SW bits)
//   out_last   head is the final sample of the trace
//   busy       high from accepted start until the trace has fully drained
//   ovf        sticky: a sample was dropped because the FIFO was full
module hd_trace_sampler #(
  parameter int WIDTH = 128,
  parameter int WIN   = 4,
  parameter int DEPTH = 16,
  parameter int SW    = $clog2(WIDTH * WIN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] nets,
  input  logic             start,
  input  logic [15:0]      nsamp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SW-1:0]    out_data,
  output logic             out_last,
  output logic             busy,
  output logic             ovf
);

  localparam int HW  = $clog2(WIDTH + 1);
  localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   prev_reg;
  logic [SW-1:0]      acc_reg;
  logic [WCW-1:0]     wcnt_reg;
  logic [15:0]        scnt_reg;
  logic [15:0]        nsamp_reg;
  logic               ovf_reg;
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [CW-1:0]      count_reg;

  // Each entry holds {last, sample}.
  logic [SW:0]        mem [DEPTH];

  logic [WIDTH-1:0]   toggle;
  logic [HW-1:0]      hd;
  logic [SW-1:0]      sum;
  logic               window_end;
  logic               is_last;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic [SW:0]        head;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_toggle
    assign toggle[gi] = nets[gi] ^ prev_reg[gi];
  end

  always_comb begin
    hd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hd = hd + HW'(toggle[i]);
    end
  end

  assign sum        = acc_reg + SW'(hd);
  assign window_end = (state_reg == RUN) && (wcnt_reg == WCW'(WIN - 1));
  assign is_last    = (scnt_reg == nsamp_reg - 16'd1);
  assign out_valid  = (count_reg != '0);
  assign full       = (count_reg == CW'(DEPTH));
  assign pop        = out_valid & out_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = window_end & (~full | pop);
  assign drop       = window_end & full & ~pop;

  assign head     = mem[rd_ptr_reg];
  // Mask the head while empty so the outputs read 0 after reset.
  assign out_data = out_valid ? head[SW-1:0] : '0;
  assign out_last = out_valid & head[SW];
  assign busy     = (state_reg != IDLE);
  assign ovf      = ovf_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= {is_last, sum};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      prev_reg   <= '0;
      acc_reg    <= '0;
      wcnt_reg   <= '0;
      scnt_reg   <= '0;
      nsamp_reg  <= '0;
      ovf_reg    <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // FIFO bookkeeping
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        ovf_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (start && (nsamp != 16'd0)) begin
            nsamp_reg <= nsamp;
            ovf_reg   <= 1'b0;
            acc_reg   <= '0;
            wcnt_reg  <= '0;
            scnt_reg  <= '0;
            state_reg <= ARM;
          end
        end
        ARM: begin
          // Baseline capture only; no toggles are counted on this edge.
          prev_reg  <= nets;
          state_reg <= RUN;
        end
        RUN: begin
          prev_reg <= nets;
          if (window_end) begin
            acc_reg  <= '0;
            wcnt_reg <= '0;
            scnt_reg <= scnt_reg + 16'd1;
            // Dropped samples still count toward the trace length.
            if (is_last) begin
              state_reg <= DRAIN;
            end
          end else begin
            acc_reg  <= sum;
            wcnt_reg <= wcnt_reg + WCW'(1);
          end
        end
        DRAIN: begin
          // Leave as the last entry is popped, or at once if already empty.
          if ((count_reg == '0) || ((count_reg == CW'(1)) && pop)) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_trace_sampler.sv
module tb_hd_trace_sampler;

  localparam int WIDTH = 128;
  localparam int WIN   = 4;
  localparam int DEPTH = 16;
  localparam int SW    = $clog2(WIDTH * WIN + 1);

  localparam int MSTATIC = 0;
  localparam int MFULL   = 1;
  localparam int MSPARSE = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] nets = '0;
  logic             start = 1'b0;
  logic [15:0]      nsamp = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [SW-1:0]    out_data;
  logic             out_last;
  logic             busy;
  logic             ovf;

  int errors = 0;
  int checks = 0;
  int m = 0;
  int mode = MSTATIC;
  logic [SW:0] sb_q[$];

  hd_trace_sampler #(.WIDTH(WIDTH), .WIN(WIN), .DEPTH(DEPTH), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .nets(nets), .start(start), .nsamp(nsamp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One edge; inputs are updated 1 time unit after it. m counts edges since
  // the START edge (e0); nets are set for the value sampled at edge m+1.
  task automatic step();
    @(posedge clk);
    #1;
    m++;
    case (mode)
      MFULL:   nets = ~nets;
      MSPARSE: nets[7] = (((m + 1) / 2) % 2) != 0;
      default: ;
    endcase
  endtask

  task automatic start_trace(input int n, input int md);
    nsamp = 16'(n);
    mode  = md;
    start = 1'b1;
    m     = -1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (m < target) step();
  endtask

  task automatic expect_samples(input int n, input int value, input bit with_last);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back({(with_last && (i == n - 1)), SW'(value)});
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && busy; i++) step();
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Scoreboard: a pop happens at the next rising edge whenever valid&ready
  // hold at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra observed=%0d/%0d expected=none", out_last, out_data);
      end
      if (sb_q.size() != 0) begin
        logic [SW:0] exp_e;
        exp_e = sb_q.pop_front();
        $display("pop data=%0d last=%0d (exp data=%0d last=%0d)",
                 out_data, out_last, exp_e[SW-1:0], exp_e[SW]);
        chk("sb_pop", 32'({out_last, out_data}), 32'(exp_e));
      end
    end
  end

  initial begin
    // Reset state
    step(); step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_data", 32'(out_data), 0);
    rst_n = 1'b1;
    step();

    // Full toggle, NSAMP=3: busy high for exactly 14 edges
    out_ready = 1'b1;
    expect_samples(3, WIDTH * WIN, 1'b1);
    start_trace(3, MFULL);
    chk("t1_busy_rise", 32'(busy), 1);
    while (m < 15) begin
      step();
      chk("t1_busy", 32'(busy), 32'(m < 14));
    end
    chk("t1_sb_empty", 32'(sb_q.size()), 0);

    // Static nets
    nets = {16{8'hA5}};
    expect_samples(2, 0, 1'b1);
    start_trace(2, MSTATIC);
    wait_idle("t2_timeout", 50);
    chk("t2_ovf", 32'(ovf), 0);
    chk("t2_sb_empty", 32'(sb_q.size()), 0);

    // Sparse toggle: bit 7 every second edge from the first RUN edge
    nets = '0;
    expect_samples(4, 2, 1'b1);
    start_trace(4, MSPARSE);
    wait_idle("t3_timeout", 50);
    chk("t3_sb_empty", 32'(sb_q.size()), 0);

    // Backpressure / overflow: 17th push at e69 is dropped
    out_ready = 1'b0;
    expect_samples(DEPTH, WIDTH * WIN, 1'b0);
    start_trace(20, MFULL);
    run_to(68);
    chk("t4_ovf_before", 32'(ovf), 0);
    chk("t4_valid_held", 32'(out_valid), 1);
    step();
    chk("t4_ovf_set", 32'(ovf), 1);
    run_to(85);
    chk("t4_busy_drain", 32'(busy), 1);
    out_ready = 1'b1;
    while (m < 102) begin
      step();
      chk("t4_busy", 32'(busy), 32'(m < 101));
    end
    chk("t4_sb_empty", 32'(sb_q.size()), 0);
    chk("t4_ovf_hold", 32'(ovf), 1);

    // START with NSAMP=0 is ignored
    mode  = MSTATIC;
    nsamp = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t5_nsamp0_busy", 32'(busy), 0);
    chk("t5_nsamp0_ovf_keep", 32'(ovf), 1);

    // START during RUN is ignored
    expect_samples(2, 0, 1'b1);
    start_trace(2, MSTATIC);
    chk("t5_ovf_clear", 32'(ovf), 0);
    run_to(4);
    nsamp = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    while (m < 11) begin
      step();
      chk("t5_busy", 32'(busy), 32'(m < 10));
    end
    chk("t5_sb_empty", 32'(sb_q.size()), 0);

    // Push and pop in the same cycle on a full FIFO
    out_ready = 1'b0;
    expect_samples(17, WIDTH * WIN, 1'b1);
    start_trace(17, MFULL);
    run_to(68);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_ovf", 32'(ovf), 0);
    chk("t6_valid", 32'(out_valid), 1);
    run_to(72);
    out_ready = 1'b1;
    wait_idle("t6_timeout", 40);
    chk("t6_sb_empty", 32'(sb_q.size()), 0);
    chk("t6_ovf_end", 32'(ovf), 0);

    // Reset mid-RUN with 5 samples queued
    out_ready = 1'b0;
    expect_samples(8, WIDTH * WIN, 1'b1);
    start_trace(8, MFULL);
    run_to(23);
    chk("t7_valid_pre", 32'(out_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7_valid", 32'(out_valid), 0);
    chk("t7_data", 32'(out_data), 0);
    chk("t7_last", 32'(out_last), 0);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_ovf", 32'(ovf), 0);
    sb_q.delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t7_valid_after", 32'(out_valid), 0);
    end
    chk("t7_busy_after", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hd_trace_sampler.md
# hd_trace_sampler

Hamming-distance trace sampler for simulation-based TVLA. Sits directly downstream of the gate-level cell netlist: it watches a bus of WIDTH netlist nets and counts bit toggles between consecutive clock edges. It sums the toggle counts over a window of WIN cycles into one power-proxy sample and streams the samples out through a FIFO with a valid/ready handshake, for consumption by the trace dump/statistics stage.

## Interface
- WIDTH, 128: number of monitored nets.
- WIN, 4: cycles accumulated per sample (≥1).
- DEPTH, 16: output FIFO entries (power of 2, ≥2).
- SW, $clog2(WIDTH*WIN+1): sample width (10 at defaults).
- CLK  in  1  clock; all state updates on rising edge.
- R  in  1  reset, asynchronous, active-low.
- NETS  in  WIDTH  monitored net values.
- START  in  1  pulse: begin one trace (honoured only in IDLE with NSAMP≠0).
- NSAMP  in  16  samples per trace; latched on accepted START.
- OUT_VALID  out  1  FIFO head valid.
- OUT_READY  in  1  consumer accepts head.
- OUT_DATA  out  SW  head sample.
- OUT_LAST  out  1  head is final sample of trace.
- BUSY  out  1  high from accepted START until trace fully drained.
- OVF  out  1  sticky: at least one sample dropped on FIFO full.

## Operation
- States: IDLE, ARM, RUN, DRAIN.
- IDLE: BUSY=0. START with NSAMP≠0 → ARM; latch NSAMP; clear OVF, acc, window count, sample count. START with NSAMP=0, or START in any other state, is ignored.
- ARM (one cycle): prev ← NETS (baseline, no sample) → RUN.
- RUN, each cycle: hd = popcount(NETS ^ prev); prev ← NETS; acc ← acc + hd; wcnt increments.
- On the WIN-th RUN cycle of a window: push {last, acc+hd} and reset acc and wcnt to 0. last = (sample count == NSAMP−1). Sample count increments; after the NSAMP-th push → DRAIN.
- Windows are back-to-back; no idle cycle between windows.
- Arithmetic is unsigned. acc is SW bits and cannot overflow (max WIDTH*WIN).
- Push when full without a same-cycle pop: sample is dropped and OVF ← 1. The sample still counts toward NSAMP. If the dropped sample was the last one, OUT_LAST never appears; OVF flags the trace as invalid.
- Push and pop in the same cycle when full: both succeed and occupancy is unchanged.
- Pop occurs when OUT_VALID & OUT_READY. OUT_VALID = FIFO not empty. OUT_DATA and OUT_LAST show the head and are stable while OUT_VALID=1 and OUT_READY=0.
- DRAIN: stay until the FIFO is empty, then go to IDLE and BUSY ← 0.
- Reset (any time, including mid-trace): state=IDLE; FIFO emptied; acc, prev, counters, OVF = 0. All outputs 0: OUT_VALID, OUT_DATA, OUT_LAST, BUSY, OVF.

## Timing
- START sampled at edge e0 → ARM during e0..e1. The baseline is captured at e1. RUN cycles are edges e2..; sample 1 covers transitions at edges e2..e(WIN+1).
- Push occurs at the edge ending the window. OUT_VALID rises after that same edge (0-cycle FIFO bypass not required; 1-edge latency from window end).
- BUSY rises after e0. It falls after the edge that pops the last entry once in DRAIN. An empty FIFO entering DRAIN makes BUSY fall 1 edge later.
- Per-trace duration with OUT_READY=1 throughout: 1 + NSAMP*WIN + 1 cycles from START to BUSY low.
- OVF updates at the drop edge and holds until reset or the next accepted START.

## Test plan
- Reset: drive R=0 mid-RUN with 5 samples queued → all outputs 0 immediately. After R=1, OUT_VALID stays 0 until a new START.
- Full toggle: NETS inverts every cycle, NSAMP=3, OUT_READY=1 → 3 samples of 512, OUT_LAST only on the 3rd, BUSY low 14 cycles after START.
- Static nets: NETS constant 128'hA5.., NSAMP=2 → samples 0, 0, OUT_LAST on the 2nd, OVF=0.
- Sparse toggle: bit 7 toggles every second cycle starting at the first RUN edge, NSAMP=4 → each sample = 2.
- Backpressure/overflow: OUT_READY=0, full toggle, NSAMP=20 → 16 entries held, OVF=1 after the 17th push. Then OUT_READY=1 → exactly 16 samples of 512 with no OUT_LAST, BUSY falls after the 16th pop.
- Edge handshakes: START with NSAMP=0 → stays IDLE. START during RUN → ignored, count unaffected. Pop+push on a full FIFO in the same cycle → occupancy 16, no OVF.
